key_conditioner: RTL and testbench
==================================

KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 The block SHALL have parameter SAMPLE_DIV, default 12000, hwclk cycles per debounce sample tick (1 kHz at 12 MHz); legal range >= 2.
REQ-002 The block SHALL have parameter STABLE_CNT, default 4, consecutive disagreeing samples needed to accept a key change; legal range 1..15.
REQ-003 The block SHALL have port hwclk, input, 1, the single system clock.
REQ-004 The block SHALL have port n_rst, input, 1, the reset; it is asynchronous and active-low.
REQ-005 The block SHALL have port piano_keys, input, 15, raw asynchronous key switches, bit i = key i.
REQ-006 The block SHALL have port keys_clean, output, 15, debounced key levels feeding the synth core.
REQ-007 The block SHALL have port key_press, output, 15, one-cycle strobe per key on accepted press.
REQ-008 The block SHALL have port key_release, output, 15, one-cycle strobe per key on accepted release.
REQ-009 The block SHALL have port active_key, output, 4, index of the highest-numbered key set in keys_clean; 0 when none.
REQ-010 The block SHALL have port key_valid, output, 1, OR of keys_clean.

Function
REQ-011 The block SHALL pass each piano_keys bit through a 2-flop synchronizer before any other use.
REQ-012 The block SHALL run a prescaler counting 0..SAMPLE_DIV-1, asserting an internal sample tick for one cycle at SAMPLE_DIV-1 and wrapping to 0 on the next cycle.
REQ-013 On a tick, for each key whose synchronized level differs from keys_clean[i], the block SHALL increment that key's 4-bit stability counter.
REQ-014 On a tick where the increment would reach STABLE_CNT, the block SHALL toggle keys_clean[i] and clear the counter in the same cycle.
REQ-015 On a tick where the synchronized level equals keys_clean[i], the block SHALL clear that key's counter (any bounce restarts qualification).
REQ-016 Between ticks, counters and keys_clean SHALL hold.
REQ-017 key_press[i] SHALL be high for exactly the one cycle in which keys_clean[i] first reads 1; key_release[i] likewise for the first cycle it reads 0.
REQ-018 All 15 keys SHALL be debounced independently; simultaneous changes on several keys in one tick SHALL each produce their own strobes in that cycle.
REQ-019 active_key and key_valid SHALL be combinational decodes of keys_clean, with no added latency.
REQ-020 Latency from a clean input edge to keys_clean SHALL be 2 cycles of synchronization plus STABLE_CNT ticks, rounded up to the next tick boundary.

Reset
REQ-021 While n_rst is low, the block SHALL clear synchronizers, prescaler, all counters, keys_clean, key_press, key_release, active_key and key_valid to 0 immediately, without waiting for hwclk.
REQ-022 After n_rst deasserts, the prescaler SHALL restart from 0; a reset asserted mid-qualification SHALL discard all partial counts, and no strobe SHALL be produced by the reset itself.

Configuration
REQ-023 With macro KEY_RELEASE_STROBE_EN defined, key_release SHALL behave per REQ-017.
REQ-024 Without KEY_RELEASE_STROBE_EN, key_release SHALL be tied to 0 and its edge logic omitted; all other behaviour SHALL be unchanged.

Verification (bench parameters SAMPLE_DIV=4, STABLE_CNT=3)
REQ-025 Reset: assert n_rst low mid-clock with keys=15'h7FFF -> all outputs 0 at once; outputs stay 0 for >= 2 ticks after release if keys=0.
REQ-026 Steady press: keys=15'h0001 held -> keys_clean[0]=1 on the 3rd tick after sync; key_press=15'h0001 for one cycle; active_key=0; key_valid=1.
REQ-027 Bounce: key 4 toggled every 5 cycles for 60 cycles, then 0 -> keys_clean stays 0 and key_press stays 0 throughout.
REQ-028 Priority: hold keys 0, 2, 4 -> active_key=4; add key 14 -> active_key=14; release key 14 -> active_key=4.
REQ-029 Release: release key 0 after acceptance -> keys_clean[0]=0 after 3 ticks; with KEY_RELEASE_STROBE_EN, key_release[0] pulses once; without it, key_release stays 0.
REQ-030 Reset mid-count: press key 7, pulse n_rst low after 2 ticks, keep key held -> keys_clean[7] rises only 3 full ticks after reset release.

Source files
------------

// File: rtl/key_conditioner.sv
// Piano key front end: synchronise, debounce on a slow sample tick, emit press/release strobes.
// Optional macro KEY_RELEASE_STROBE_EN enables the key_release strobes (tied to 0 otherwise).
`timescale 1ns/1ps

module key_conditioner #(
  parameter int SAMPLE_DIV = 12000,
  parameter int STABLE_CNT = 4
) (
  input  logic        hwclk,
  input  logic        n_rst,
  input  logic [14:0] piano_keys,
  output logic [14:0] keys_clean,
  output logic [14:0] key_press,
  output logic [14:0] key_release,
  output logic [3:0]  active_key,
  output logic        key_valid
);

  localparam int              DIV_W    = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [3:0]      CNT_LAST = 4'(STABLE_CNT - 1);

  logic [14:0]       r_meta;
  logic [14:0]       r_sync;
  logic [DIV_W-1:0]  r_div;
  logic [14:0][3:0]  r_cnt;
  logic [14:0]       r_clean;
  logic [14:0]       r_press;

  logic              w_tick;
  logic [14:0]       w_diff;
  logic [14:0]       w_toggle;
  logic [14:0][3:0]  w_cnt_nxt;

  assign w_tick = (r_div == DIV_LAST);
  assign w_diff = r_sync ^ r_clean;

  // A key flips only when the tick that would complete its count arrives.
  always_comb begin
    w_toggle  = '0;
    w_cnt_nxt = r_cnt;
    for (int i = 0; i < 15; i++) begin
      if (w_tick) begin
        if (w_diff[i] && (r_cnt[i] == CNT_LAST)) begin
          w_toggle[i]  = 1'b1;
          w_cnt_nxt[i] = 4'd0;
        end else if (w_diff[i]) begin
          w_cnt_nxt[i] = r_cnt[i] + 4'd1;
        end else begin
          w_cnt_nxt[i] = 4'd0;
        end
      end
    end
  end

  always_ff @(posedge hwclk or negedge n_rst) begin
    if (!n_rst) begin
      r_meta  <= '0;
      r_sync  <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_clean <= '0;
      r_press <= '0;
    end else begin
      r_meta  <= piano_keys;
      r_sync  <= r_meta;
      r_div   <= w_tick ? '0 : r_div + 1'b1;
      r_cnt   <= w_cnt_nxt;
      r_clean <= r_clean ^ w_toggle;
      r_press <= w_toggle & ~r_clean;
    end
  end

`ifdef KEY_RELEASE_STROBE_EN
  logic [14:0] r_release;

  always_ff @(posedge hwclk or negedge n_rst) begin
    if (!n_rst) begin
      r_release <= '0;
    end else begin
      r_release <= w_toggle & r_clean;
    end
  end

  assign key_release = r_release;
`else
  assign key_release = '0;
`endif

  // Highest-numbered held key wins.
  always_comb begin
    active_key = 4'd0;
    for (int i = 0; i < 15; i++) begin
      if (r_clean[i]) active_key = 4'(i);
    end
  end

  assign keys_clean = r_clean;
  assign key_press  = r_press;
  assign key_valid  = |r_clean;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with SAMPLE_DIV=4, STABLE_CNT=3 and a strobe scoreboard.
`timescale 1ns/1ps

module tb_key_conditioner;

  localparam int SD = 4;
  localparam int SC = 3;
`ifdef KEY_RELEASE_STROBE_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic        hwclk = 1'b0;
  logic        n_rst = 1'b0;
  logic [14:0] piano_keys = '0;
  logic [14:0] keys_clean;
  logic [14:0] key_press;
  logic [14:0] key_release;
  logic [3:0]  active_key;
  logic        key_valid;

  typedef struct {
    int          at_edge;
    logic [14:0] press;
    logic [14:0] rel;
    logic [14:0] clean;
  } ev_t;

  ev_t  q[$];
  ev_t  mon_ev;
  logic [14:0] mon_ep;
  logic [14:0] mon_er;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  key_conditioner #(.SAMPLE_DIV(SD), .STABLE_CNT(SC)) dut (
    .hwclk      (hwclk),
    .n_rst      (n_rst),
    .piano_keys (piano_keys),
    .keys_clean (keys_clean),
    .key_press  (key_press),
    .key_release(key_release),
    .active_key (active_key),
    .key_valid  (key_valid)
  );

  always #5 hwclk = ~hwclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Edge c is the last clock before the input changes; samples fall on every SD-th edge
  // after reset release, the first usable one being at least 2 sync edges later.
  function automatic int clean_edge(input int c);
    int first;
    first = ((c + 3 + SD - 1) / SD) * SD;
    return first + (SC - 1) * SD;
  endfunction

  task automatic drive(input logic [14:0] keys, output int e);
    ev_t ev;
    @(negedge hwclk);
    ev.at_edge = clean_edge(cyc);
    ev.press   = keys & ~piano_keys;
    ev.rel     = REL_EN ? (~keys & piano_keys) : 15'h0;
    ev.clean   = keys;
    piano_keys = keys;
    q.push_back(ev);
    e = ev.at_edge;
  endtask

  task automatic run_to(input int e);
    int guard;
    guard = 0;
    while (cyc < e) begin
      @(negedge hwclk);
      guard++;
      if (guard > 500) begin
        $display("FAIL run_to: cycle %0d never reached %0d", cyc, e);
        $fatal(1, "cycle budget exhausted");
      end
    end
  endtask

  // Scoreboard: every active cycle compare strobes, popping expected events at their edge.
  initial begin
    forever begin
      @(posedge hwclk);
      if (!n_rst) cyc = 0;
      else cyc++;
      #1;
      if (n_rst) begin
        mon_ep = '0;
        mon_er = '0;
        if (q.size() > 0 && q[0].at_edge < cyc) begin
          chk("missed_event", cyc, q[0].at_edge);
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].at_edge == cyc) begin
          mon_ev = q.pop_front();
          mon_ep = mon_ev.press;
          mon_er = mon_ev.rel;
          chk("clean_at_event", keys_clean, mon_ev.clean);
        end
        chk("press_strobe", key_press, mon_ep);
        chk("release_strobe", key_release, mon_er);
      end
    end
  end

  initial begin
    int e;
    int s1;
    ev_t ev;

    repeat (3) @(negedge hwclk);
    chk("rst_clean", keys_clean, 0);
    chk("rst_press", key_press, 0);
    chk("rst_active", active_key, 0);
    chk("rst_valid", key_valid, 0);
    n_rst = 1'b1;

    drive(15'h7FFF, e);
    run_to(e + 2);
    chk("all_clean", keys_clean, 15'h7FFF);
    chk("all_active", active_key, 14);
    chk("all_valid", key_valid, 1);

    @(negedge hwclk);
    #2;
    n_rst = 1'b0;
    q.delete();
    #1;
    chk("async_rst_clean", keys_clean, 0);
    chk("async_rst_active", active_key, 0);
    chk("async_rst_valid", key_valid, 0);
    piano_keys = '0;
    @(negedge hwclk);
    n_rst = 1'b1;
    repeat (12) begin
      @(negedge hwclk);
      chk("post_rst_quiet", keys_clean, 0);
    end

    drive(15'h0001, e);
    run_to(e - 1);
    chk("press_not_early", keys_clean, 0);
    run_to(e);
    chk("press_clean", keys_clean, 15'h0001);
    chk("press_active", active_key, 0);
    chk("press_valid", key_valid, 1);

    for (int i = 0; i < 12; i++) begin
      piano_keys[4] = ~piano_keys[4];
      repeat (5) @(negedge hwclk);
      chk("bounce_clean", keys_clean, 15'h0001);
    end
    piano_keys[4] = 1'b0;
    repeat (12) @(negedge hwclk);
    chk("bounce_final", keys_clean, 15'h0001);

    drive(15'h0015, e);
    run_to(e + 1);
    chk("prio_024", active_key, 4);
    drive(15'h4015, e);
    run_to(e + 1);
    chk("prio_14", active_key, 14);
    drive(15'h0015, e);
    run_to(e + 1);
    chk("prio_back_4", active_key, 4);
    chk("prio_clean", keys_clean, 15'h0015);

    drive(15'h0014, e);
    run_to(e + 1);
    chk("rel0_clean", keys_clean[0], 0);
    chk("rel0_active", active_key, 4);
    drive(15'h0000, e);
    run_to(e + 1);
    chk("rel_all_valid", key_valid, 0);
    chk("rel_all_active", active_key, 0);

    drive(15'h0080, e);
    s1 = e - (SC - 1) * SD;
    run_to(s1 + SD);
    n_rst = 1'b0;
    q.delete();
    #1;
    chk("midrst_clean", keys_clean, 0);
    @(negedge hwclk);
    n_rst = 1'b1;
    ev.at_edge = SC * SD;
    ev.press   = 15'h0080;
    ev.rel     = 15'h0;
    ev.clean   = 15'h0080;
    q.push_back(ev);
    run_to(SC * SD - 1);
    chk("midrst_not_early", keys_clean, 0);
    run_to(SC * SD);
    chk("midrst_clean_rise", keys_clean, 15'h0080);
    chk("midrst_active", active_key, 7);

    repeat (4) @(negedge hwclk);
    chk("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
